// File: rtl/proc_states_operations_pkg.sv
// ============================================================================
// proc_states_operations_pkg : datapath operation codes and register-file type
// Rev 1.0
// ============================================================================
`default_nettype none

package proc_states_operations_pkg;

  // Eight 8-bit registers, element index is the register number.
  typedef logic [7:0][7:0] a_sc_unsigned_8_8;

  typedef enum logic [4:0] {
    proc_states_op_idle         = 5'd0,
    proc_states_op_fetch_1      = 5'd1,
    proc_states_op_decode_2     = 5'd2,
    proc_states_op_decode_3     = 5'd3,
    proc_states_op_decode_4     = 5'd4,
    proc_states_op_decode_5     = 5'd5,
    proc_states_op_execute_6    = 5'd6,
    proc_states_op_execute_7    = 5'd7,
    proc_states_op_execute_8    = 5'd8,
    proc_states_op_execute_9    = 5'd9,
    proc_states_op_execute_10   = 5'd10,
    proc_states_op_execute_11   = 5'd11,
    proc_states_op_execute_12   = 5'd12,
    proc_states_op_memory_14    = 5'd14,
    proc_states_op_memory_15    = 5'd15,
    proc_states_op_writeback_16 = 5'd16,
    proc_states_op_writeback_17 = 5'd17,
    proc_states_op_writeback_18 = 5'd18,
    proc_states_op_writeback_19 = 5'd19
  } proc_states_operations_t;

endpackage

`default_nettype wire

// File: rtl/proc_states_package.sv
// ============================================================================
// proc_states_package : sequencer states, instruction classes, field helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package proc_states_package;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } proc_state_t;

  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_OR   = 4'd1,
    CLS_ADDI = 4'd2,
    CLS_ORI  = 4'd3,
    CLS_LD   = 4'd4,
    CLS_ST   = 4'd5,
    CLS_BRZ  = 4'd6,
    CLS_JMP  = 4'd7,
    CLS_HALT = 4'd8,
    CLS_NOP  = 4'd9
  } instr_class_t;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_OR   = 4'h1;
  localparam logic [3:0] OPC_ADDI = 4'h2;
  localparam logic [3:0] OPC_ORI  = 4'h3;
  localparam logic [3:0] OPC_LD   = 4'h4;
  localparam logic [3:0] OPC_ST   = 4'h5;
  localparam logic [3:0] OPC_BRZ  = 4'h6;
  localparam logic [3:0] OPC_JMP  = 4'h7;
  localparam logic [3:0] OPC_HALT = 4'hF;

  function automatic logic [3:0] field_op(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [2:0] field_ra(input logic [15:0] instr);
    return instr[11:9];
  endfunction

  function automatic logic [2:0] field_rb(input logic [15:0] instr);
    return instr[8:6];
  endfunction

  function automatic logic [2:0] field_rd(input logic [15:0] instr);
    return instr[5:3];
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_states_control_if.sv
// ============================================================================
// proc_states_control_if : datapath <-> sequencer handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface proc_states_control_if
  import proc_states_operations_pkg::*;
;
  logic [15:0]             instr_in;
  a_sc_unsigned_8_8        reg_file_in;
  logic                    imem_ready;
  logic                    dmem_ready;
  proc_states_operations_t operation;
  logic                    halted;
  logic                    mem_err;

  modport master (
    output instr_in, reg_file_in, imem_ready, dmem_ready,
    input  operation, halted, mem_err
  );

  modport slave (
    input  instr_in, reg_file_in, imem_ready, dmem_ready,
    output operation, halted, mem_err
  );

endinterface

`default_nettype wire

// File: rtl/proc_states_decoder.sv
// ============================================================================
// proc_states_decoder : opcode -> instruction class, zero test for branches
// Rev 1.0
// ============================================================================
`default_nettype none

module proc_states_decoder
  import proc_states_package::*;
(
  input  logic [3:0]   opcode,
  input  logic [7:0]   ra_value,
  output instr_class_t cls,
  output logic         ra_zero
);

  always_comb begin
    cls = CLS_NOP;
    case (opcode)
      OPC_ADD:  cls = CLS_ADD;
      OPC_OR:   cls = CLS_OR;
      OPC_ADDI: cls = CLS_ADDI;
      OPC_ORI:  cls = CLS_ORI;
      OPC_LD:   cls = CLS_LD;
      OPC_ST:   cls = CLS_ST;
      OPC_BRZ:  cls = CLS_BRZ;
      OPC_JMP:  cls = CLS_JMP;
      OPC_HALT: cls = CLS_HALT;
      default:  cls = CLS_NOP;
    endcase
  end

  assign ra_zero = (ra_value == 8'd0);

endmodule

`default_nettype wire

// File: rtl/proc_states_control.sv
// ============================================================================
// proc_states_control : fetch/decode/execute/memory/writeback sequencer
// Optional perf counters: define PROC_CTRL_PERF_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module proc_states_control
  import proc_states_package::*;
  import proc_states_operations_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
)
(
  input  logic             clk,
  input  logic             rst,
`ifdef PROC_CTRL_PERF_EN
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  proc_states_control_if.slave bus
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
  // The cycle that would be the WAIT_LIMIT-th in a wait state ends the wait.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  proc_state_t             state;
  instr_class_t            cls;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    halted;
  logic                    mem_err;

  instr_class_t            dec_cls;
  logic                    ra_zero;
  logic [3:0]              opcode;
  logic [7:0]              ra_value;
  proc_states_operations_t op_next;
  logic                    waiting;
  logic                    wait_hit;
  logic                    advance;

  assign opcode   = field_op(bus.instr_in);
  assign ra_value = bus.reg_file_in[field_ra(bus.instr_in)];

  proc_states_decoder u_decoder (
    .opcode   (opcode),
    .ra_value (ra_value),
    .cls      (dec_cls),
    .ra_zero  (ra_zero)
  );

  always_comb begin
    op_next  = proc_states_op_idle;
    waiting  = 1'b0;
    wait_hit = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_hit = 1'b1;
        end else if (bus.imem_ready) begin
          op_next = proc_states_op_fetch_1;
          advance = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_BRZ:  op_next = ra_zero ? proc_states_op_decode_2 : proc_states_op_decode_3;
          CLS_JMP:  op_next = proc_states_op_decode_4;
          CLS_HALT: op_next = proc_states_op_idle;
          default:  op_next = proc_states_op_decode_5;
        endcase
      end
      ST_EXECUTE: begin
        case (cls)
          CLS_ADD:  op_next = proc_states_op_execute_7;
          CLS_OR:   op_next = proc_states_op_execute_8;
          CLS_ADDI: op_next = proc_states_op_execute_10;
          CLS_ORI:  op_next = proc_states_op_execute_11;
          CLS_ST:   op_next = proc_states_op_execute_6;
          CLS_LD:   op_next = proc_states_op_execute_12;
          default:  op_next = proc_states_op_execute_9;
        endcase
      end
      ST_MEMORY: begin
        if (cls == CLS_LD || cls == CLS_ST) begin
          if (wait_cnt == WAIT_LAST) begin
            wait_hit = 1'b1;
          end else if (bus.dmem_ready) begin
            op_next = (cls == CLS_LD) ? proc_states_op_memory_14 : proc_states_op_memory_15;
            advance = 1'b1;
          end else begin
            waiting = 1'b1;
          end
        end else begin
          op_next = proc_states_op_memory_15;
          advance = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        case (cls)
          CLS_LD:           op_next = proc_states_op_writeback_16;
          CLS_ADD, CLS_OR:  op_next = proc_states_op_writeback_17;
          CLS_ADDI, CLS_ORI: op_next = proc_states_op_writeback_18;
          default:          op_next = proc_states_op_writeback_19;
        endcase
      end
      default: op_next = proc_states_op_idle;
    endcase
    if (rst) begin
      op_next  = proc_states_op_idle;
      waiting  = 1'b0;
      wait_hit = 1'b0;
      advance  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      cls      <= CLS_NOP;
      wait_cnt <= '0;
      halted   <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH, ST_MEMORY: begin
          if (wait_hit) begin
            state    <= ST_HALT;
            halted   <= 1'b1;
            mem_err  <= 1'b1;
            wait_cnt <= '0;
          end else if (advance) begin
            state    <= (state == ST_FETCH) ? ST_DECODE : ST_WRITEBACK;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          cls <= dec_cls;
          case (dec_cls)
            CLS_BRZ, CLS_JMP: state <= ST_FETCH;
            CLS_HALT: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            default: state <= ST_EXECUTE;
          endcase
        end
        ST_EXECUTE:   state  <= ST_MEMORY;
        ST_WRITEBACK: state  <= ST_FETCH;
        ST_HALT:      halted <= 1'b1;
        default: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.operation = op_next;
  assign bus.halted    = halted;
  assign bus.mem_err   = mem_err;

`ifdef PROC_CTRL_PERF_EN
  logic retire;
  assign retire = op_next inside {proc_states_op_decode_2, proc_states_op_decode_3,
                                  proc_states_op_decode_4, proc_states_op_writeback_16,
                                  proc_states_op_writeback_17, proc_states_op_writeback_18,
                                  proc_states_op_writeback_19};

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire && retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
      if ((waiting || wait_hit) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_states_control.sv
// ============================================================================
// tb_proc_states_control : randomized bench with a per-instruction sequence model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_proc_states_control;
  import proc_states_operations_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  proc_states_control_if bus_if();

`ifdef PROC_CTRL_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  proc_states_control #(.WAIT_LIMIT(255), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef PROC_CTRL_PERF_EN
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .bus         (bus_if)
  );

  // One expected cycle: operation plus how to drive the ready inputs (-1 = random).
  typedef struct {
    proc_states_operations_t op;
    int                      imem;
    int                      dmem;
  } step_t;

  step_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic proc_states_operations_t exec_op(input logic [3:0] opc);
    case (opc)
      4'h0:    return proc_states_op_execute_7;
      4'h1:    return proc_states_op_execute_8;
      4'h2:    return proc_states_op_execute_10;
      4'h3:    return proc_states_op_execute_11;
      4'h4:    return proc_states_op_execute_12;
      4'h5:    return proc_states_op_execute_6;
      default: return proc_states_op_execute_9;
    endcase
  endfunction

  function automatic proc_states_operations_t wb_op(input logic [3:0] opc);
    case (opc)
      4'h4:       return proc_states_op_writeback_16;
      4'h0, 4'h1: return proc_states_op_writeback_17;
      4'h2, 4'h3: return proc_states_op_writeback_18;
      default:    return proc_states_op_writeback_19;
    endcase
  endfunction

  task automatic push(input proc_states_operations_t op, input int im, input int dm);
    step_t s;
    s.op   = op;
    s.imem = im;
    s.dmem = dm;
    exp_q.push_back(s);
  endtask

  // Expected cycle sequence for one instruction given fetch and memory wait counts.
  task automatic build(input logic [15:0] ins, input a_sc_unsigned_8_8 rf, input int fd, input int md);
    logic [3:0] opc;
    logic [7:0] va;
    opc = ins[15:12];
    va  = rf[ins[11:9]];
    exp_q.delete();
    for (int i = 0; i < fd; i++) push(proc_states_op_idle, 0, -1);
    push(proc_states_op_fetch_1, 1, -1);
    case (opc)
      4'h6: push((va == 8'd0) ? proc_states_op_decode_2 : proc_states_op_decode_3, -1, -1);
      4'h7: push(proc_states_op_decode_4, -1, -1);
      4'hF: push(proc_states_op_idle, -1, -1);
      default: begin
        push(proc_states_op_decode_5, -1, -1);
        push(exec_op(opc), -1, -1);
        if (opc == 4'h4 || opc == 4'h5) begin
          for (int i = 0; i < md; i++) push(proc_states_op_idle, -1, 0);
          push((opc == 4'h4) ? proc_states_op_memory_14 : proc_states_op_memory_15, -1, 1);
        end else begin
          push(proc_states_op_memory_15, -1, -1);
        end
        push(wb_op(opc), -1, -1);
      end
    endcase
  endtask

  task automatic play(input logic [15:0] ins, input a_sc_unsigned_8_8 rf);
    foreach (exp_q[i]) begin
      @(negedge clk);
      bus_if.instr_in    = ins;
      bus_if.reg_file_in = rf;
      bus_if.imem_ready  = (exp_q[i].imem < 0) ? 1'($urandom) : 1'(exp_q[i].imem);
      bus_if.dmem_ready  = (exp_q[i].dmem < 0) ? 1'($urandom) : 1'(exp_q[i].dmem);
      #1;
      check_val($sformatf("op ins=%h cyc=%0d", ins, i), 32'(bus_if.operation), 32'(exp_q[i].op));
    end
    check_val($sformatf("halted ins=%h", ins), 32'(bus_if.halted), 32'd0);
    check_val($sformatf("mem_err ins=%h", ins), 32'(bus_if.mem_err), 32'd0);
  endtask

  task automatic run_instr(input logic [15:0] ins, input a_sc_unsigned_8_8 rf, input int fd, input int md);
    build(ins, rf, fd, md);
    play(ins, rf);
  endtask

  task automatic check_halt(input string tag, input logic exp_err);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_if.imem_ready = 1'b1;
      bus_if.dmem_ready = 1'b1;
      #1;
      check_val({tag, " op"}, 32'(bus_if.operation), 32'(proc_states_op_idle));
      check_val({tag, " halted"}, 32'(bus_if.halted), 32'd1);
      check_val({tag, " mem_err"}, 32'(bus_if.mem_err), 32'(exp_err));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus_if.imem_ready = 1'b1;
    bus_if.dmem_ready = 1'b1;
    #1;
    check_val({tag, " op during rst"}, 32'(bus_if.operation), 32'(proc_states_op_idle));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val({tag, " halted after rst"}, 32'(bus_if.halted), 32'd0);
    check_val({tag, " mem_err after rst"}, 32'(bus_if.mem_err), 32'd0);
`ifdef PROC_CTRL_PERF_EN
    check_val({tag, " retired_cnt"}, retired_cnt, 32'd0);
    check_val({tag, " stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  function automatic a_sc_unsigned_8_8 rand_rf();
    a_sc_unsigned_8_8 rf;
    for (int i = 0; i < 8; i++) rf[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
    return rf;
  endfunction

  initial begin
    a_sc_unsigned_8_8 rf;
    logic [15:0]      ins;

    bus_if.instr_in    = '0;
    bus_if.reg_file_in = '0;
    bus_if.imem_ready  = 1'b0;
    bus_if.dmem_ready  = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("init");

    rf = rand_rf();
    run_instr(16'h0298, rf, 0, 0);
    run_instr(16'h4240, rf, 0, 3);
    rf[2] = 8'd0;
    run_instr(16'h6405, rf, 0, 0);
    rf[2] = 8'd7;
    run_instr(16'h6405, rf, 0, 0);
    run_instr(16'h7123, rf, 2, 0);

    // Longest waits that still complete.
    run_instr(16'h0298, rand_rf(), 253, 0);
    run_instr(16'h4240, rand_rf(), 0, 253);

    for (int n = 0; n < 40; n++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ins, rand_rf(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run_instr(16'hF000, rf, 1, 0);
    check_halt("halt", 1'b0);
    do_reset("halt");
    run_instr(16'h1040, rand_rf(), 0, 0);

    // ST whose data memory never answers; ready arriving on the limit cycle is ignored.
    rf = rand_rf();
    build(16'h5280, rf, 0, 254);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    push(proc_states_op_idle, -1, 1);
    play(16'h5280, rf);
    check_halt("wait_limit", 1'b1);
    do_reset("wait_limit");

    // Reset in the middle of an LD memory wait.
    rf = rand_rf();
    build(16'h4240, rf, 1, 5);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    play(16'h4240, rf);
    do_reset("mid_ld");
    run_instr(16'h0298, rf, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
